// File: rtl/taus_stream_checker_if.sv
// Word stream handshake between a taus88 source and the stream checker.
interface taus_stream_checker_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;

  modport master (output data_in, valid_in, input ready_out);
  modport slave  (input data_in, valid_in, output ready_out);
endinterface

// File: rtl/taus_stream_checker.sv
// taus88 stream checker: hunts for alignment with a local model, then counts mismatches.
// Optional build macro TAUS_CHK_RESYNC_EN: ERR_LIMIT consecutive mismatches force a re-hunt.
module taus_stream_checker #(
  parameter logic [31:0] SEED1     = 32'd12345,
  parameter logic [31:0] SEED2     = 32'd12345,
  parameter logic [31:0] SEED3     = 32'd12345,
  parameter int          LOCK_CNT  = 4,
  parameter int          ERR_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  taus_stream_checker_if.slave         s_if,
  output logic                         locked,
  output logic                         match_pulse,
  output logic                         error_pulse,
  output logic [15:0]                  error_count,
  output logic [31:0]                  word_count
);
  localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
  localparam logic [7:0] ERR_N  = ERR_LIMIT[7:0];

  typedef enum logic [1:0] {INIT, HUNT, LOCKED} state_e;

  function automatic logic [31:0] t1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction
  function automatic logic [31:0] t2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction
  function automatic logic [31:0] t3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, exp_q, exp_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [7:0]  erun_q, erun_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic        ready_q, ready_d, locked_q, locked_d;
  logic        match_q, match_d, error_q, error_d;

  logic [31:0] n1, n2, n3, r1, r2, r3;
  logic        accept, hit;

  // s*_q is the model state whose output word is exp_q
  always_comb begin
    n1 = t1(s1_q);  n2 = t2(s2_q);  n3 = t3(s3_q);
    r1 = t1(SEED1); r2 = t2(SEED2); r3 = t3(SEED3);
    accept = s_if.valid_in && ready_q;
    hit    = (s_if.data_in == exp_q);

    state_d = state_q;
    s1_d = s1_q; s2_d = s2_q; s3_d = s3_q; exp_d = exp_q;
    mcnt_d = mcnt_q; erun_d = erun_q; ecnt_d = ecnt_q; wcnt_d = wcnt_q;
    match_d = 1'b0; error_d = 1'b0;

    case (state_q)
      INIT: begin
        s1_d = n1; s2_d = n2; s3_d = n3; exp_d = n1 ^ n2 ^ n3;
        state_d = HUNT;
      end
      HUNT: if (accept) begin
        if (hit) begin
          match_d = 1'b1;
          s1_d = n1; s2_d = n2; s3_d = n3; exp_d = n1 ^ n2 ^ n3;
          if (mcnt_q + 4'd1 == LOCK_N) begin
            state_d = LOCKED;
            mcnt_d  = 4'd0;
            erun_d  = 8'd0;
          end else begin
            mcnt_d = mcnt_q + 4'd1;
          end
        end else begin
          mcnt_d = 4'd0;
          s1_d = r1; s2_d = r2; s3_d = r3; exp_d = r1 ^ r2 ^ r3;
        end
      end
      LOCKED: if (accept) begin
        s1_d = n1; s2_d = n2; s3_d = n3; exp_d = n1 ^ n2 ^ n3;
        wcnt_d = wcnt_q + 32'd1;
        if (hit) begin
          match_d = 1'b1;
          erun_d  = 8'd0;
        end else begin
          error_d = 1'b1;
          if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
          if (erun_q != ERR_N)    erun_d = erun_q + 8'd1;
`ifdef TAUS_CHK_RESYNC_EN
          if (erun_q + 8'd1 == ERR_N) begin
            state_d = HUNT;
            erun_d  = 8'd0;
            mcnt_d  = 4'd0;
            s1_d = r1; s2_d = r2; s3_d = r3; exp_d = r1 ^ r2 ^ r3;
          end
`endif
        end
      end
      default: state_d = INIT;
    endcase

    ready_d  = (state_d != INIT);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      s1_q <= SEED1; s2_q <= SEED2; s3_q <= SEED3; exp_q <= 32'd0;
      mcnt_q <= 4'd0; erun_q <= 8'd0; ecnt_q <= 16'd0; wcnt_q <= 32'd0;
      ready_q <= 1'b0; locked_q <= 1'b0; match_q <= 1'b0; error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d; s2_q <= s2_d; s3_q <= s3_d; exp_q <= exp_d;
      mcnt_q <= mcnt_d; erun_q <= erun_d; ecnt_q <= ecnt_d; wcnt_q <= wcnt_d;
      ready_q <= ready_d; locked_q <= locked_d; match_q <= match_d; error_q <= error_d;
    end
  end

  assign s_if.ready_out = ready_q;
  assign locked         = locked_q;
  assign match_pulse    = match_q;
  assign error_pulse    = error_q;
  assign error_count    = ecnt_q;
  assign word_count     = wcnt_q;
endmodule

// File: tb/tb_taus_stream_checker.sv
// Directed bench for taus_stream_checker; reference words come from a local taus88 recurrence.
module tb_taus_stream_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        locked, match_pulse, error_pulse;
  logic [15:0] error_count;
  logic [31:0] word_count;
  int          n_chk = 0;
  int          n_fail = 0;

  taus_stream_checker_if bus ();

  taus_stream_checker dut (
    .clk(clk), .rst(rst_n), .s_if(bus.slave),
    .locked(locked), .match_pulse(match_pulse), .error_pulse(error_pulse),
    .error_count(error_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Word n of the reference stream: state after n+1 steps from 12345 seeds.
  function automatic logic [31:0] tw(input int n);
    logic [31:0] a, b, c;
    a = 32'd12345; b = 32'd12345; c = 32'd12345;
    for (int k = 0; k <= n; k++) begin
      a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
      b = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
      c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
    end
    return a ^ b ^ c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.data_in  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and confirm the single INIT cycle with ready low.
  task automatic do_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_ready_lo", {31'd0, bus.ready_out}, 32'd0);
    @(posedge clk);
    #1 check("hunt_ready_hi", {31'd0, bus.ready_out}, 32'd1);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 4; i++) send(tw(i));
    check("lock_up", {31'd0, locked}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 32'd0;
    #12;
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_match", {31'd0, match_pulse}, 32'd0);
    check("rst_error", {31'd0, error_pulse}, 32'd0);
    check("rst_ecnt", {16'd0, error_count}, 32'd0);
    check("rst_wcnt", word_count, 32'd0);

    // Clean stream, with a word offered during INIT that must be ignored
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = tw(0);
    #1 check("init_ready_lo", {31'd0, bus.ready_out}, 32'd0);
    @(posedge clk);
    #1 check("init_no_match", {31'd0, match_pulse}, 32'd0);
    check("hunt_ready_hi", {31'd0, bus.ready_out}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      send(tw(i));
      check($sformatf("clean_match%0d", i), {31'd0, match_pulse}, 32'd1);
      check($sformatf("clean_locked%0d", i), {31'd0, locked}, (i >= 3) ? 32'd1 : 32'd0);
    end
    check("clean_wcnt", word_count, 32'd6);
    check("clean_ecnt", {16'd0, error_count}, 32'd0);
    idle();
    check("idle_no_match", {31'd0, match_pulse}, 32'd0);
    check("idle_wcnt", word_count, 32'd6);

    // Garbage before the stream start
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(32'hDEADBEEF);
      check("garb_match", {31'd0, match_pulse}, 32'd0);
      check("garb_error", {31'd0, error_pulse}, 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      send(tw(i));
      check($sformatf("garb_match%0d", i), {31'd0, match_pulse}, 32'd1);
      check($sformatf("garb_locked%0d", i), {31'd0, locked}, (i >= 3) ? 32'd1 : 32'd0);
    end
    check("garb_wcnt", word_count, 32'd4);
    check("garb_ecnt", {16'd0, error_count}, 32'd0);

    // Offset stream never aligns with word 0
    do_reset();
    for (int i = 5; i <= 20; i++) begin
      send(tw(i));
      check($sformatf("ofs_locked%0d", i), {31'd0, locked}, 32'd0);
      check($sformatf("ofs_match%0d", i), {31'd0, match_pulse}, 32'd0);
    end
    check("ofs_ecnt", {16'd0, error_count}, 32'd0);

    // Single corrupted word while locked
    do_reset();
    lock_up();
    send(tw(4) ^ 32'd1);
    check("c1_error", {31'd0, error_pulse}, 32'd1);
    check("c1_match", {31'd0, match_pulse}, 32'd0);
    check("c1_ecnt", {16'd0, error_count}, 32'd1);
    check("c1_locked", {31'd0, locked}, 32'd1);
    for (int i = 5; i < 8; i++) begin
      send(tw(i));
      check($sformatf("c1_after_match%0d", i), {31'd0, match_pulse}, 32'd1);
      check($sformatf("c1_after_error%0d", i), {31'd0, error_pulse}, 32'd0);
    end
    check("c1_ecnt_end", {16'd0, error_count}, 32'd1);
    check("c1_wcnt_end", word_count, 32'd4);

    // Eight consecutive corrupted words
    do_reset();
    lock_up();
    for (int i = 4; i < 12; i++) begin
      send(tw(i) ^ 32'd1);
      check($sformatf("c8_error%0d", i), {31'd0, error_pulse}, 32'd1);
`ifdef TAUS_CHK_RESYNC_EN
      check($sformatf("c8_locked%0d", i), {31'd0, locked}, (i == 11) ? 32'd0 : 32'd1);
`else
      check($sformatf("c8_locked%0d", i), {31'd0, locked}, 32'd1);
`endif
    end
    check("c8_ecnt", {16'd0, error_count}, 32'd8);
    check("c8_wcnt", word_count, 32'd8);
`ifdef TAUS_CHK_RESYNC_EN
    lock_up();
    check("resync_ecnt_kept", {16'd0, error_count}, 32'd8);
    check("resync_wcnt_kept", word_count, 32'd8);
    send(tw(4));
    check("resync_wcnt_inc", word_count, 32'd9);
`else
    send(tw(12));
    check("sticky_match", {31'd0, match_pulse}, 32'd1);
    check("sticky_wcnt", word_count, 32'd9);
`endif

    // Asynchronous reset in the middle of a locked stream
    do_reset();
    lock_up();
    for (int i = 4; i < 9; i++) send(tw(i) ^ 32'h8000_0000);
    check("mid_ecnt", {16'd0, error_count}, 32'd5);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("async_ready", {31'd0, bus.ready_out}, 32'd0);
    check("async_locked", {31'd0, locked}, 32'd0);
    check("async_error", {31'd0, error_pulse}, 32'd0);
    check("async_match", {31'd0, match_pulse}, 32'd0);
    check("async_ecnt", {16'd0, error_count}, 32'd0);
    check("async_wcnt", word_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_init_ready", {31'd0, bus.ready_out}, 32'd0);
    @(posedge clk);
    #1 check("post_hunt_ready", {31'd0, bus.ready_out}, 32'd1);
    send(tw(0));
    check("post_match_w0", {31'd0, match_pulse}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/taus_stream_checker.md
Name: taus_stream_checker

Overview:
- Receiving end of the Tausworthe (taus88) random-word stream: consumes 32-bit words with a valid strobe.
- Runs its own taus88 model from the same seeds and hunts for alignment with the incoming stream.
- Once aligned, checks every word and counts mismatches.
- Sits downstream of the generator, e.g. on a loopback or link test path.

Parameters:
- SEED1, 32'd12345, initial s1 (must be > 1)
- SEED2, 32'd12345, initial s2 (must be > 7)
- SEED3, 32'd12345, initial s3 (must be > 15)
- LOCK_CNT, 4, consecutive matches required in HUNT to enter LOCKED (1..15)
- ERR_LIMIT, 8, consecutive mismatches in LOCKED that force re-hunt (1..255)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  32  incoming random word
- valid_in  in  1  data_in valid; a word is accepted when valid_in && ready_out
- ready_out  out  1  checker can accept a word
- locked  out  1  high in LOCKED state
- match_pulse  out  1  one-cycle pulse: the accepted word matched the expected word
- error_pulse  out  1  one-cycle pulse: mismatch while LOCKED
- error_count  out  16  mismatches counted in LOCKED, saturating at 16'hFFFF
- word_count  out  32  words accepted while LOCKED, wraps modulo 2^32

Behaviour:
- Reset (rst low, asynchronous):
  - Model state is loaded with SEED1..3; state = INIT.
  - All outputs are 0: ready_out, locked, match_pulse, error_pulse, error_count, word_count.
- Model step, taus88:
  - s1' = ((s1 & FFFFFFFE)<<12) ^ (((s1<<13)^s1)>>19)
  - s2' = ((s2 & FFFFFFF8)<<4) ^ (((s2<<2)^s2)>>25)
  - s3' = ((s3 & FFFFFFF0)<<17) ^ (((s3<<3)^s3)>>11)
  - Expected word = s1'^s2'^s3', taken from the next state, so word 0 is the output after one step from the seeds.
  - All arithmetic is 32-bit unsigned; shifted-out bits are discarded.
- FSM states: INIT, HUNT, LOCKED.
- INIT:
  - Lasts exactly one cycle after reset release, with ready_out=0.
  - Registers expected word 0, then goes to HUNT.
- HUNT (ready_out=1):
  - On accept with data_in == expected: match_pulse=1, the model steps, match counter +1.
  - When the match counter reaches LOCK_CNT: go to LOCKED and clear the counter.
  - On accept with a mismatch: the model does NOT step, the match counter clears, and the model state is reloaded with the seeds (expected word 0).
  - error_pulse and error_count are never affected in HUNT.
- LOCKED (ready_out=1, locked=1):
  - The model steps on every accepted word, match or not.
  - word_count increments on every accept.
  - On a mismatch: error_pulse=1, error_count +1 (saturating), consecutive-error counter +1.
  - On a match: match_pulse=1 and the consecutive-error counter clears.
- Latency: pulses and counters update on the clock edge that accepts the word, so they are visible the cycle after valid_in.
- No accept means no state change; pulses are 0.
- Back-to-back accepts every cycle are supported at full rate.
- Reset asserted mid-stream returns the block to INIT immediately and clears all counters.
- valid_in during INIT is ignored (ready_out=0), and the word is not accepted.

Optional Feature:
- Macro: TAUS_CHK_RESYNC_EN
- Defined:
  - ERR_LIMIT consecutive mismatches in LOCKED move the FSM to HUNT with the seeds reloaded.
  - locked drops on the next cycle.
  - error_count and word_count are retained.
- Undefined: LOCKED is sticky until reset, and ERR_LIMIT is unused.

Test Plan:
- Reset, then drive reference taus88 words 0..9 from seeds 12345 on consecutive cycles -> ready_out=1 from the 2nd cycle after release; locked=1 after the 4th match; word_count=6; error_count=0.
- Drive 3 garbage words (32'hDEADBEEF), then words 0..7 -> no match_pulse on the garbage words; lock after word 3; error_count=0.
- Stream offset: feed words 5..20 -> remains in HUNT with locked=0 for all 16 words.
- Locked, then corrupt one word (bit 0 flipped) -> a single error_pulse; error_count=1; locked stays 1; the following words match.
- TAUS_CHK_RESYNC_EN defined: locked, then 8 consecutive corrupted words -> error_count=8 and locked=0 the cycle after the 8th. Undefined: locked stays 1 and error_count=8.
- Assert rst low mid-stream while LOCKED with error_count=5 -> all outputs 0 asynchronously; INIT for one cycle after release.
